// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for EX (shift-add / restoring).
// Ports: clk, reset, start, Flush, MulDivOp, SrcA, SrcB; out busy, done,
// MulDivResult. Define MULDIV_FAST_MUL_EN for a single-cycle multiply.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  Flush,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] MulDivResult
);

  localparam int W = DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(W - 1);
  localparam logic [W-1:0] MIN_NEG =
    {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]   op_q;
  logic [W-1:0] mag;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] res;
  logic         neg_q;
  logic         neg_r;
  logic [5:0]   cnt;

  logic         signed_a;
  logic         signed_b;
  logic         sign_a;
  logic         sign_b;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;
  logic         is_div;
  logic         div_zero;
  logic         div_ovf;
  logic         special;
  logic [W-1:0] special_res;
  logic         fast;
  logic [W-1:0] fast_res;

  logic [W:0]     sum;
  logic [W:0]     rem_sh;
  logic [W+1:0]   diff;
  logic           ge;
  logic [W-1:0]   hi_nxt;
  logic [W-1:0]   lo_nxt;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   calc_res;
  logic           start_go;
  logic           calc_go;
  logic           unused;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    unique case (MulDivOp)
      3'b001, 3'b100, 3'b110: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'b010: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign sign_a = signed_a & SrcA[W-1];
  assign sign_b = signed_b & SrcB[W-1];
  assign abs_a  = sign_a ? -SrcA : SrcA;
  assign abs_b  = sign_b ? -SrcB : SrcB;

  assign is_div   = MulDivOp[2];
  assign div_zero = is_div && (SrcB == '0);
  // Only the signed ops can overflow (MIN / -1).
  assign div_ovf  = is_div && !MulDivOp[0] &&
                    (SrcA == MIN_NEG) && (SrcB == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = MulDivOp[1] ? SrcA : '1;
    end else begin
      special_res = MulDivOp[1] ? '0 : MIN_NEG;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]       fa;
  logic signed [W:0]       fb;
  logic signed [2*W+1:0]   fp;

  // sign_x doubles as the 33rd bit: zero for unsigned operands.
  assign fa = {sign_a, SrcA};
  assign fb = {sign_b, SrcB};
  assign fp = (2*W+2)'(fa) * (2*W+2)'(fb);
  assign fast = !is_div;
  assign fast_res = (MulDivOp[1:0] == 2'b00) ?
                    fp[W-1:0] : fp[2*W-1:W];
  logic unused_fast;
  assign unused_fast = ^fp[2*W+1:2*W];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  // Multiply: {carry,hi,lo} shifts right, lo holds the multiplier.
  assign sum = {1'b0, hi} +
               (lo[0] ? {1'b0, mag} : '0);

  // Divide: hi is the partial remainder, lo shifts the
  // dividend out and the quotient in.
  assign rem_sh = {hi, lo[W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, mag};
  assign ge     = ~diff[W+1];

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (op_q[2]) begin
      hi_nxt = ge ? diff[W-1:0] : rem_sh[W-1:0];
      lo_nxt = {lo[W-2:0], ge};
    end else begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], lo[W-1:1]};
    end
  end

  assign prod   = {hi_nxt, lo_nxt};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -lo_nxt : lo_nxt;
  assign rem_s  = neg_r ? -hi_nxt : hi_nxt;

  always_comb begin
    calc_res = '0;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_s : quo_s;
    end else if (op_q[1:0] == 2'b00) begin
      calc_res = prod_s[W-1:0];
    end else begin
      calc_res = prod_s[2*W-1:W];
    end
  end

  // Partial remainder is always below the divisor.
  assign unused = diff[W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (special || fast) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Flush) begin
      state_nxt = IDLE;
    end
  end

  assign start_go = (state == IDLE) && start && !Flush;
  assign calc_go  = (state == CALC) && !Flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      mag   <= '0;
      hi    <= '0;
      lo    <= '0;
      res   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
    end else if (start_go) begin
      op_q  <= MulDivOp;
      mag   <= is_div ? abs_b : abs_a;
      hi    <= '0;
      lo    <= is_div ? abs_a : abs_b;
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
      cnt   <= '0;
      if (special) begin
        res <= special_res;
      end else if (fast) begin
        res <= fast_res;
      end
    end else if (calc_go) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 6'd1;
      if (cnt == LAST) begin
        res <= calc_res;
      end
    end
  end

  assign busy         = (state == CALC);
  assign done         = (state == DONE);
  assign MulDivResult = res;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic model, per-cycle
// compare of busy/done/MulDivResult, plus flush and reset cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Flush;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] MulDivResult;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Flush(Flush),
    .MulDivOp(MulDivOp),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .busy(busy),
    .done(done),
    .MulDivResult(MulDivResult)
  );

  int n_chk = 0;
  int n_fail = 0;

  int req = 0;
  int ack = 0;
  int k = 0;
  bit idle_chk = 1'b0;
  bit iter;
  string cur_nm = "";
  logic [31:0] exp_res;
  logic [31:0] prev_res;
  logic [31:0] cur_res;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b);
    longint          p;
    longint unsigned up;
    int              ia;
    int              ib;
    logic [31:0]     r;
    bit              ovf;
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin
        p = longint'(ia) * longint'(ib);
        r = p[31:0];
      end
      3'd1: begin
        p = longint'(ia) * longint'(ib);
        r = p[63:32];
      end
      3'd2: begin
        p = longint'(ia) * longint'({32'b0, b});
        r = p[63:32];
      end
      3'd3: begin
        up = {32'b0, a} * {32'b0, b};
        r = up[63:32];
      end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else r = ia / ib;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_iter(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b);
    bit it;
    it = 1'b1;
    if (op[2] && ((b == 0) ||
        (!op[0] && a == 32'h8000_0000 &&
         b == 32'hFFFF_FFFF))) begin
      it = 1'b0;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) it = 1'b0;
`endif
    return it;
  endfunction

  // k counts cycles after the start-sampling edge: iterative ops are
  // busy for k=0..31 and done at k=32; one-cycle ops are done at k=0.
  always @(negedge clk) begin
    int dk;
    if (req != ack) begin
      dk = iter ? 32 : 0;
      chk({cur_nm, " busy"}, {31'b0, busy},
          {31'b0, (iter && k < 32)});
      chk({cur_nm, " done"}, {31'b0, done},
          {31'b0, (k == dk)});
      chk({cur_nm, " result"}, MulDivResult,
          (k >= dk) ? exp_res : prev_res);
      k++;
      if (k > dk) begin
        k = 0;
        ack = req;
      end
    end else if (idle_chk) begin
      chk("idle busy", {31'b0, busy}, 32'd0);
      chk("idle done", {31'b0, done}, 32'd0);
      chk("idle result", MulDivResult, cur_res);
    end
  end

  task automatic do_op(input string nm,
                       input logic [2:0]  op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] lit,
                       input int pulse_k);
    @(posedge clk);
    #1;
    start    = 1'b1;
    MulDivOp = op;
    SrcA     = a;
    SrcB     = b;
    cur_nm   = nm;
    exp_res  = model(op, a, b);
    prev_res = cur_res;
    iter     = is_iter(op, a, b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    MulDivOp = 3'($urandom);
    SrcA     = $urandom;
    SrcB     = $urandom;
    req++;
    for (int g = 0; g < 60 && req != ack; g++) begin
      @(posedge clk);
      #1;
      start = (k == pulse_k);
    end
    start = 1'b0;
    chk({nm, " completion"}, 32'(req - ack), 32'd0);
    chk({nm, " literal"}, MulDivResult, lit);
    cur_res = exp_res;
  endtask

  task automatic flush_at(input int n);
    int nd;
    idle_chk = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    MulDivOp = 3'b100;
    SrcA     = 32'd1000;
    SrcB     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    Flush = 1'b1;
    @(negedge clk);
    chk("flush pre busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    Flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush result", MulDivResult, cur_res);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("flush no done", 32'(nd), 32'd0);
    chk("flush held", MulDivResult, cur_res);
    idle_chk = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    Flush    = 1'b0;
    MulDivOp = '0;
    SrcA     = '0;
    SrcB     = '0;
    cur_res  = '0;
    #1;
    reset = 1'b1;
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", MulDivResult, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    idle_chk = 1'b1;

    do_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFEB, 5);
    do_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32);
    do_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'h0, -1);
    do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, -1);
    do_op("MULH min", 3'd1, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, -1);
    do_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFD, 7);
    do_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, -1);
    do_op("REM negdiv", 3'd6, 32'd7, 32'hFFFF_FFFE,
          32'd1, -1);
    do_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 32);
    do_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, -1);
    do_op("DIVU max", 3'd5, 32'hFFFF_FFFF, 32'd1,
          32'hFFFF_FFFF, -1);
    do_op("DIVU by0", 3'd5, 32'd5, 32'd0,
          32'hFFFF_FFFF, -1);
    do_op("REM by0", 3'd6, 32'd5, 32'd0, 32'd5, -1);
    do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, -1);
    do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, -1);
    do_op("DIVU pre", 3'd5, 32'd100, 32'd7, 32'd14, -1);

    flush_at(10);
    flush_at(32);

    @(posedge clk);
    #1;
    start    = 1'b1;
    Flush    = 1'b1;
    MulDivOp = 3'b101;
    SrcA     = 32'd9;
    SrcB     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    Flush = 1'b0;
    @(negedge clk);
    chk("start+flush busy", {31'b0, busy}, 32'd0);
    chk("start+flush done", {31'b0, done}, 32'd0);
    repeat (35) @(negedge clk);

    idle_chk = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b1;
    MulDivOp = 3'b101;
    SrcA     = 32'hFFFF_FFFF;
    SrcB     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async busy", {31'b0, busy}, 32'd0);
    chk("async done", {31'b0, done}, 32'd0);
    chk("async result", MulDivResult, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    cur_res  = '0;
    idle_chk = 1'b1;

    do_op("MUL after rst", 3'd0, 32'd3, 32'd4, 32'd12, 5);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
